// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
// Address sequencer for the 3-to-8 decoder. Walks the enabled (mask=1)
// decoder outputs in ascending order and holds each one for dwell+1 cycles.
// Single-sweep mode ends with a one-cycle done pulse. Continuous mode wraps
// back to the lowest enabled address and pulses wrap on that cycle.
//
// Ports
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : begin a sweep (sampled only while idle)
//   stop       : synchronous abort, wins over start/advance/done/wrap
//   mode       : 0 single sweep, 1 continuous (latched on accepted start)
//   mask[7:0]  : address enables (latched on accepted start)
//   dwell      : hold time minus one (latched on accepted start)
//   sel[2:0]   : decoder address A
//   en         : decoder enable En (mirrors busy)
//   busy       : high while scanning
//   done       : one-cycle pulse after the last address of a single sweep
//   wrap       : one-cycle pulse on the first cycle of a repeated sweep
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  // Index of the lowest set bit; 0 when the vector is empty (callers
  // only use the result when at least one bit is set).
  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [7:0]           mask_q;
  logic                 mode_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [2:0]           sel_q, sel_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap_q, wrap_d;

  logic                 accept;
  logic [7:0]           above;
  logic                 has_higher;
  logic                 cnt_zero;
  logic                 sweep_end;

  // Start is only honoured in IDLE, without a concurrent stop, and with at
  // least one enabled address; an empty mask leaves the block idle.
  assign accept     = (state_q == S_IDLE) && start && !stop && (|mask);

  // Enabled addresses strictly above the current one. The shift drops
  // bits off the top, so sel=7 yields an empty set.
  assign above      = mask_q & (8'hFE << sel_q);
  assign has_higher = |above;
  assign cnt_zero   = (cnt_q == '0);
  assign sweep_end  = cnt_zero && !has_higher;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_SCAN;
      S_SCAN: begin
        if (stop)                       state_d = S_IDLE;
        else if (sweep_end && !mode_q)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- outputs
  // Computes the next value of every registered output and the counter.
  always_comb begin
    sel_d  = sel_q;
    en_d   = en_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    wrap_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        sel_d  = 3'd0;
        en_d   = 1'b0;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (accept) begin
          sel_d  = lowest_idx(mask);
          en_d   = 1'b1;
          busy_d = 1'b1;
          cnt_d  = dwell;
        end
      end
      S_SCAN: begin
        if (stop) begin
          sel_d  = 3'd0;
          en_d   = 1'b0;
          busy_d = 1'b0;
          cnt_d  = '0;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (has_higher) begin
          sel_d = lowest_idx(above);
          cnt_d = dwell_q;
        end else if (mode_q) begin
          sel_d  = lowest_idx(mask_q);
          cnt_d  = dwell_q;
          wrap_d = 1'b1;
        end else begin
          sel_d  = 3'd0;
          en_d   = 1'b0;
          busy_d = 1'b0;
          cnt_d  = '0;
          done_d = 1'b1;
        end
      end
      default: begin
        sel_d  = 3'd0;
        en_d   = 1'b0;
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 3'd0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      en_q   <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  // Sweep configuration is frozen at the accepted start; later input
  // changes only matter for the next sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= 8'd0;
      mode_q  <= 1'b0;
      dwell_q <= '0;
    end else if (accept) begin
      mask_q  <= mask;
      mode_q  <= mode;
      dwell_q <= dwell;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule
